hangman_control: RTL and testbench
==================================

# hangman_control

Top-level sequencer for the hangman game datapath. It accepts the secret word from the keyboard and then runs the drawing phases in order: dashes, gallows, guess compare, fill, body part and clear. It tracks word length, letters remaining, misses and already-guessed letters, and raises one-cycle win/lose pulses for the score registers. It sits between the PS/2 keyboard decoder and the datapath/VGA drawing engines.

## Interface
- MAX_LEN, 16: maximum letters in the secret word (≤31).
- MAX_MISS, 6: misses that end the round (head, body, 2 arms, 2 legs).
- clk  in  1  system clock (50 MHz).
- resetn  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle pulse: key_code is valid.
- key_code  in  5  letter code, 1..26 = A..Z; 0 and 27..31 are non-letters.
- key_enter  in  1  one-cycle pulse: end of word entry.
- cmp_done  in  1  datapath finished a full compare pass over the word.
- hits  in  5  number of word positions matching the guess; valid with cmp_done.
- draw_done  in  1  the active drawing engine (dash/graph/fill/part/clear) finished.
- timeout  in  1  guess timer expired.
- ld  out  1  one-cycle write strobe: store char_out at next word address.
- char_out  out  5  latched letter being written; valid with ld.
- dash, ld_g, fill, draw, over  out  1  phase enables, each held for its whole phase.
- compare  out  1  compare enable, held until cmp_done.
- timecount  out  1  guess timer run enable.
- guess_out  out  5  latched current guess.
- part  out  3  index of the body part being drawn (0 = head .. 5 = right leg).
- word_len  out  5  accepted letter count.
- win, lose  out  1  one-cycle result pulses.

## Operation
- States: IDLE, LOAD, DASH, GRAPH, GUESS, CMP, FILL, PART, WIN, LOSE, OVER.
- IDLE: all counters 0, used-letter mask cleared. A valid letter moves to LOAD and is accepted as the first letter.
- LOAD: each valid letter with word_len < MAX_LEN gives ld=1 for one cycle, char_out=key_code, word_len+1.
  - Letters beyond MAX_LEN and non-letter codes are ignored.
  - key_enter with word_len ≥ 1 loads remaining=word_len and moves to DASH. key_enter with word_len = 0 is impossible in LOAD.
- DASH (dash=1) → GRAPH (ld_g=1) → GUESS. Each phase advances on draw_done.
- GUESS (timecount=1):
  - A valid letter not yet in the used mask latches guess_out, sets its mask bit and moves to CMP.
  - Repeated letters and non-letters are ignored.
  - timeout moves to LOSE. timeout wins over a same-cycle key.
- CMP (compare=1): on cmp_done, sample hits.
  - hits > 0 → FILL.
  - hits = 0 → PART, with part=misses.
- FILL (fill=1): on draw_done, remaining = remaining − hits, saturating at 0.
  - remaining = 0 → WIN; otherwise → GUESS.
- PART (draw=1): on draw_done, misses+1.
  - misses = MAX_MISS → LOSE; otherwise → GUESS.
- WIN / LOSE: one cycle each, pulsing the matching output, then → OVER.
- OVER (over=1): on draw_done → IDLE. word_len, misses, remaining and the mask are cleared.
- timeout outside GUESS is ignored. draw_done and cmp_done outside their phase state are ignored.

## Timing
- Reset: state=IDLE; every output 0; char_out, guess_out, part, word_len = 0.
- Phase enables and timecount decode from the state register (Moore): asserted the cycle after the transition, deasserted the cycle after the done input.
- Outputs driven from registers in the same cycle as the decoded enables:
  - ld and char_out appear the cycle after key_valid.
  - win and lose are high for exactly the one cycle spent in WIN/LOSE.
- draw_done/cmp_done are honoured in any cycle of the phase state, including its first cycle.
- At most one letter is accepted per cycle.
- Reset mid-phase drops all enables within the reset assertion. No partial word is retained.
- part is stable for the whole PART state. misses updates only on leaving PART.

## Structure
- hangman_pkg holds:
  - the state enum;
  - letter code constants (LETTER_A=1, LETTER_Z=26);
  - MAX_LEN and MAX_MISS defaults;
  - the is_letter() function.
- One sub-module, guess_mask: a 26-bit used-letter register with set, clear and test ports.

## Test plan
- Reset, then type C,A,T, then enter → three ld pulses with char_out 3,1,20, word_len=3, dash held until draw_done, then ld_g.
- Word CAT: guess A (hits=1), then C, then T → three FILL phases, remaining 3→2→1→0, win pulses once, over asserts, IDLE after draw_done.
- Six distinct misses → part 0..5 on successive PART phases, lose pulses after the sixth draw_done, misses never reaches 7.
- Guess A twice → second A ignored, no compare, state stays GUESS. Code 0 also ignored.
- timeout in GUESS (same cycle as key_valid) → LOSE; timeout during FILL → ignored.
- Seventeen letters typed with MAX_LEN=16 → exactly 16 ld pulses. resetn low during PART → all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/hangman_pkg.sv
// Shared constants, state encoding and letter helper for the hangman control path.
package hangman_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE  = 4'd0;
    localparam state_t ST_LOAD  = 4'd1;
    localparam state_t ST_DASH  = 4'd2;
    localparam state_t ST_GRAPH = 4'd3;
    localparam state_t ST_GUESS = 4'd4;
    localparam state_t ST_CMP   = 4'd5;
    localparam state_t ST_FILL  = 4'd6;
    localparam state_t ST_PART  = 4'd7;
    localparam state_t ST_WIN   = 4'd8;
    localparam state_t ST_LOSE  = 4'd9;
    localparam state_t ST_OVER  = 4'd10;

    localparam logic [4:0] LETTER_A = 5'd1;
    localparam logic [4:0] LETTER_Z = 5'd26;

    localparam int unsigned MAX_LEN_DEF  = 16;
    localparam int unsigned MAX_MISS_DEF = 6;

    function automatic logic is_letter(input logic [4:0] code);
        return (code >= LETTER_A) && (code <= LETTER_Z);
    endfunction

endpackage

// File: rtl/hangman_control_guess_mask.sv
// Used-letter register: one bit per letter A..Z, bulk clear, single-bit set and test.
module guess_mask
    import hangman_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_set,
    input  logic [4:0] i_set_code,
    input  logic       i_clr,
    input  logic [4:0] i_test_code,
    output logic       o_used
);

    logic [25:0] r_mask;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mask <= '0;
        end else if (i_clr) begin
            r_mask <= '0;
        end else if (i_set && is_letter(i_set_code)) begin
            r_mask[i_set_code - LETTER_A] <= 1'b1;
        end
    end

    // Non-letter codes never index the mask.
    assign o_used = is_letter(i_test_code) && r_mask[i_test_code - LETTER_A];

endmodule

// File: rtl/hangman_control.sv
// Game sequencer: word entry, drawing phases, guess bookkeeping and win/lose pulses.
module hangman_control
    import hangman_pkg::*;
#(
    parameter int unsigned MAX_LEN  = MAX_LEN_DEF,
    parameter int unsigned MAX_MISS = MAX_MISS_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       key_valid,
    input  logic [4:0] key_code,
    input  logic       key_enter,
    input  logic       cmp_done,
    input  logic [4:0] hits,
    input  logic       draw_done,
    input  logic       timeout,
    output logic       ld,
    output logic [4:0] char_out,
    output logic       dash,
    output logic       ld_g,
    output logic       fill,
    output logic       draw,
    output logic       over,
    output logic       compare,
    output logic       timecount,
    output logic [4:0] guess_out,
    output logic [2:0] part,
    output logic [4:0] word_len,
    output logic       win,
    output logic       lose
);

    localparam logic [4:0] L_MAX_LEN  = 5'(MAX_LEN);
    localparam logic [2:0] L_MAX_MISS = 3'(MAX_MISS);

    state_t     r_state;
    state_t     w_state_d;
    logic       r_ld;
    logic [4:0] r_char;
    logic [4:0] r_guess;
    logic [2:0] r_part;
    logic [4:0] r_len;
    logic [4:0] r_remaining;
    logic [4:0] r_hits;
    logic [2:0] r_misses;

    logic       w_key_letter;
    logic       w_used;
    logic       w_load;
    logic       w_start;
    logic       w_guess;
    logic       w_cmp_end;
    logic       w_fill_end;
    logic       w_part_end;
    logic       w_clear;
    logic [4:0] w_rem_sub;

    assign w_key_letter = key_valid && is_letter(key_code);
    assign w_rem_sub    = (r_remaining > r_hits) ? (r_remaining - r_hits) : 5'd0;

    always_comb begin
        w_state_d  = r_state;
        w_load     = 1'b0;
        w_start    = 1'b0;
        w_guess    = 1'b0;
        w_cmp_end  = 1'b0;
        w_fill_end = 1'b0;
        w_part_end = 1'b0;
        w_clear    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_key_letter) begin
                    w_state_d = ST_LOAD;
                    w_load    = 1'b1;
                end
            end
            ST_LOAD: begin
                // Enter wins over a same-cycle letter so the word length is final.
                if (key_enter && (r_len != 5'd0)) begin
                    w_state_d = ST_DASH;
                    w_start   = 1'b1;
                end else if (w_key_letter && (r_len < L_MAX_LEN)) begin
                    w_load = 1'b1;
                end
            end
            ST_DASH:  if (draw_done) w_state_d = ST_GRAPH;
            ST_GRAPH: if (draw_done) w_state_d = ST_GUESS;
            ST_GUESS: begin
                if (timeout) begin
                    w_state_d = ST_LOSE;
                end else if (w_key_letter && !w_used) begin
                    w_state_d = ST_CMP;
                    w_guess   = 1'b1;
                end
            end
            ST_CMP: begin
                if (cmp_done) begin
                    w_cmp_end = 1'b1;
                    w_state_d = (hits != 5'd0) ? ST_FILL : ST_PART;
                end
            end
            ST_FILL: begin
                if (draw_done) begin
                    w_fill_end = 1'b1;
                    w_state_d  = (w_rem_sub == 5'd0) ? ST_WIN : ST_GUESS;
                end
            end
            ST_PART: begin
                if (draw_done) begin
                    w_part_end = 1'b1;
                    w_state_d  = ((r_misses + 3'd1) == L_MAX_MISS) ? ST_LOSE : ST_GUESS;
                end
            end
            ST_WIN:  w_state_d = ST_OVER;
            ST_LOSE: w_state_d = ST_OVER;
            ST_OVER: begin
                if (draw_done) begin
                    w_state_d = ST_IDLE;
                    w_clear   = 1'b1;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_ld        <= 1'b0;
            r_char      <= '0;
            r_guess     <= '0;
            r_part      <= '0;
            r_len       <= '0;
            r_remaining <= '0;
            r_hits      <= '0;
            r_misses    <= '0;
        end else begin
            r_state <= w_state_d;
            r_ld    <= w_load;
            if (w_load) begin
                r_char <= key_code;
                r_len  <= r_len + 5'd1;
            end
            if (w_start) r_remaining <= r_len;
            if (w_guess) r_guess <= key_code;
            if (w_cmp_end) begin
                r_hits <= hits;
                if (hits == 5'd0) r_part <= r_misses;
            end
            if (w_fill_end) r_remaining <= w_rem_sub;
            if (w_part_end) r_misses <= r_misses + 3'd1;
            if (w_clear) begin
                r_len       <= '0;
                r_remaining <= '0;
                r_misses    <= '0;
            end
        end
    end

    guess_mask u_guess_mask (
        .clk         (clk),
        .resetn      (resetn),
        .i_set       (w_guess),
        .i_set_code  (key_code),
        .i_clr       (w_clear),
        .i_test_code (key_code),
        .o_used      (w_used)
    );

    always_comb begin
        dash      = (r_state == ST_DASH);
        ld_g      = (r_state == ST_GRAPH);
        timecount = (r_state == ST_GUESS);
        compare   = (r_state == ST_CMP);
        fill      = (r_state == ST_FILL);
        draw      = (r_state == ST_PART);
        win       = (r_state == ST_WIN);
        lose      = (r_state == ST_LOSE);
        over      = (r_state == ST_OVER);
    end

    assign ld        = r_ld;
    assign char_out  = r_char;
    assign guess_out = r_guess;
    assign part      = r_part;
    assign word_len  = r_len;

endmodule

// File: tb/tb_hangman_control.sv
// Randomized game-level bench: the bench plays keyboard and datapath against a rules model.
module tb_hangman_control;

    localparam int MAX_LEN  = 16;
    localparam int MAX_MISS = 6;

    localparam logic [8:0] PH_NONE  = 9'h000;
    localparam logic [8:0] PH_DASH  = 9'h100;
    localparam logic [8:0] PH_GRAPH = 9'h080;
    localparam logic [8:0] PH_FILL  = 9'h040;
    localparam logic [8:0] PH_PART  = 9'h020;
    localparam logic [8:0] PH_OVER  = 9'h010;
    localparam logic [8:0] PH_CMP   = 9'h008;
    localparam logic [8:0] PH_GUESS = 9'h004;
    localparam logic [8:0] PH_WIN   = 9'h002;
    localparam logic [8:0] PH_LOSE  = 9'h001;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       key_valid = 1'b0;
    logic [4:0] key_code = '0;
    logic       key_enter = 1'b0;
    logic       cmp_done = 1'b0;
    logic [4:0] hits = '0;
    logic       draw_done = 1'b0;
    logic       timeout = 1'b0;
    logic       ld, dash, ld_g, fill, draw, over, compare, timecount, win, lose;
    logic [4:0] char_out, guess_out, word_len;
    logic [2:0] part;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0] q_keys[$];
    logic [4:0] q_guesses[$];

    hangman_control #(.MAX_LEN(MAX_LEN), .MAX_MISS(MAX_MISS)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_enter (key_enter),
        .cmp_done  (cmp_done),
        .hits      (hits),
        .draw_done (draw_done),
        .timeout   (timeout),
        .ld        (ld),
        .char_out  (char_out),
        .dash      (dash),
        .ld_g      (ld_g),
        .fill      (fill),
        .draw      (draw),
        .over      (over),
        .compare   (compare),
        .timecount (timecount),
        .guess_out (guess_out),
        .part      (part),
        .word_len  (word_len),
        .win       (win),
        .lose      (lose)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] phase();
        return {dash, ld_g, fill, draw, over, compare, timecount, win, lose};
    endfunction

    function automatic bit letter(input logic [4:0] c);
        return (c >= 5'd1) && (c <= 5'd26);
    endfunction

    task automatic tick();
        @(negedge clk);
        hits = 5'($urandom_range(0, 31));
    endtask

    task automatic pulse_key(input logic [4:0] c, input logic tmo);
        key_valid = 1'b1;
        key_code  = c;
        timeout   = tmo;
        tick();
        key_valid = 1'b0;
        timeout   = 1'b0;
    endtask

    // Idle a few cycles in a phase, optionally firing inputs that phase must ignore.
    // noise: bit0 timeout, bit1 draw_done, bit2 cmp_done.
    task automatic hold(input string tag, input logic [8:0] exp, input logic [2:0] noise);
        int n = $urandom_range(0, 3);
        repeat (n) begin
            timeout   = noise[0] && ($urandom_range(0, 1) == 1);
            draw_done = noise[1] && ($urandom_range(0, 1) == 1);
            cmp_done  = noise[2] && ($urandom_range(0, 1) == 1);
            tick();
            timeout   = 1'b0;
            draw_done = 1'b0;
            cmp_done  = 1'b0;
            check(tag, 32'(phase()), 32'(exp));
        end
    endtask

    task automatic finish_draw();
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        #1;
        check("reset_outs", 32'({phase(), ld}), 32'd0);
        check("reset_regs", 32'({char_out, guess_out, part, word_len}), 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        check("after_reset", 32'({phase(), ld, word_len}), 32'd0);
    endtask

    // Play one round: type q_keys, then guesses from q_guesses (random when exhausted).
    task automatic play_game(input int tmo_at, input bit abort_in_part);
        logic [4:0] word[$];
        bit         used[32];
        int         len = 0;
        int         rem;
        int         misses = 0;
        int         attempts = 0;
        int         h;
        int         r;
        logic [4:0] c;
        bit         won = 0;
        foreach (used[i]) used[i] = 0;

        foreach (q_keys[i]) begin
            c = q_keys[i];
            pulse_key(c, 1'b0);
            if (letter(c) && len < MAX_LEN) begin
                len++;
                word.push_back(c);
                check("ld_pulse", 32'(ld), 32'd1);
                check("char_out", 32'(char_out), 32'(c));
            end else begin
                check("ld_ignored", 32'(ld), 32'd0);
            end
            check("word_len", 32'(word_len), 32'(len));
        end
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
        check("enter_dash", 32'({phase(), ld}), 32'({PH_DASH, 1'b0}));
        hold("dash_hold", PH_DASH, 3'b101);
        finish_draw();
        check("graph", 32'(phase()), 32'(PH_GRAPH));
        hold("graph_hold", PH_GRAPH, 3'b101);
        finish_draw();
        check("guess_entry", 32'(phase()), 32'(PH_GUESS));
        check("len_kept", 32'(word_len), 32'(len));
        rem = len;

        forever begin
            if (attempts == tmo_at || attempts >= 100) begin
                pulse_key(5'($urandom_range(1, 26)), 1'b1);
                check("timeout_lose", 32'(phase()), 32'(PH_LOSE));
                break;
            end
            attempts++;
            if (q_guesses.size() > 0) begin
                c = q_guesses.pop_front();
            end else begin
                r = $urandom_range(0, 9);
                if (r < 4)      c = word[$urandom_range(0, word.size() - 1)];
                else if (r < 8) c = 5'($urandom_range(1, 26));
                else            c = 5'($urandom_range(0, 31));
            end
            pulse_key(c, 1'b0);
            if (!letter(c) || used[c]) begin
                check("guess_ignored", 32'(phase()), 32'(PH_GUESS));
                continue;
            end
            used[c] = 1;
            check("compare", 32'(phase()), 32'(PH_CMP));
            check("guess_out", 32'(guess_out), 32'(c));
            h = 0;
            foreach (word[i]) if (word[i] == c) h++;
            hold("cmp_hold", PH_CMP, 3'b011);
            cmp_done = 1'b1;
            hits     = 5'(h);
            @(negedge clk);
            cmp_done = 1'b0;
            hits     = 5'($urandom_range(0, 31));
            if (h > 0) begin
                check("fill", 32'(phase()), 32'(PH_FILL));
                hold("fill_hold", PH_FILL, 3'b101);
                finish_draw();
                rem = (rem > h) ? rem - h : 0;
                if (rem == 0) begin
                    check("win", 32'(phase()), 32'(PH_WIN));
                    won = 1;
                    break;
                end
                check("fill_back", 32'(phase()), 32'(PH_GUESS));
            end else begin
                check("part_phase", 32'(phase()), 32'(PH_PART));
                check("part_idx", 32'(part), 32'(misses));
                if (abort_in_part) begin
                    resetn = 1'b0;
                    #1;
                    check("abort_outs", 32'({phase(), ld, word_len}), 32'd0);
                    tick();
                    resetn = 1'b1;
                    tick();
                    check("abort_idle", 32'({phase(), ld, word_len}), 32'd0);
                    return;
                end
                hold("part_hold", PH_PART, 3'b101);
                check("part_stable", 32'(part), 32'(misses));
                finish_draw();
                misses++;
                if (misses == MAX_MISS) begin
                    check("miss_lose", 32'(phase()), 32'(PH_LOSE));
                    break;
                end
                check("part_back", 32'(phase()), 32'(PH_GUESS));
            end
        end

        tick();
        check("over", 32'(phase()), 32'(PH_OVER));
        hold("over_hold", PH_OVER, 3'b101);
        finish_draw();
        check("idle_again", 32'({phase(), word_len}), 32'd0);
        if (won) check("won_flag", 32'(rem), 32'd0);
    endtask

    task automatic random_word();
        int n = $urandom_range(1, 18);
        q_keys.delete();
        q_keys.push_back(5'($urandom_range(1, 26)));
        for (int i = 1; i < n; i++) begin
            if ($urandom_range(0, 6) == 0) q_keys.push_back(5'($urandom_range(0, 31)));
            else                           q_keys.push_back(5'($urandom_range(1, 26)));
        end
    endtask

    initial begin
        tick();
        apply_reset();

        // CAT with a repeated A and a non-letter mixed in.
        q_keys    = '{5'd3, 5'd1, 5'd20};
        q_guesses = '{5'd1, 5'd1, 5'd0, 5'd3, 5'd20};
        play_game(-1, 0);

        // Six distinct misses.
        q_keys    = '{5'd1, 5'd2};
        q_guesses = '{5'd26, 5'd25, 5'd24, 5'd23, 5'd22, 5'd21};
        play_game(-1, 0);

        // Timeout with a same-cycle key on the first guess.
        q_keys = '{5'd3, 5'd1, 5'd20};
        q_guesses.delete();
        play_game(0, 0);

        // Seventeen letters: the last must be dropped.
        q_keys.delete();
        for (int i = 0; i < 17; i++) q_keys.push_back(5'(1 + (i % 26)));
        play_game(-1, 0);

        // Reset in the middle of a body-part draw.
        q_keys    = '{5'd1};
        q_guesses = '{5'd2};
        play_game(-1, 1);

        for (int g = 0; g < 25; g++) begin
            random_word();
            q_guesses.delete();
            play_game(($urandom_range(0, 4) == 0) ? $urandom_range(0, 8) : -1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
